o_bus_rr_pick_fifo: RTL and testbench

O_BUS_RR_PICK_FIFO -- requirements
Module: o_bus_rr_pick_fifo

---
 rtl/o_bus_rr_pick_fifo.sv | 103 ++++++++++
 tb/tb_o_bus_rr_pick_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/o_bus_rr_pick_fifo.sv
// Round-robin picker of N request channels feeding a small in-order output FIFO.
// Optional feature: define O_BUS_PICK_ID_EN to add o_id (source channel stored per entry).
module o_bus_rr_pick_fifo #(
   parameter int NUM_INPUT_DATA = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_INPUT_DATA-1:0]            i_valid,
   input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
   output logic [NUM_INPUT_DATA-1:0]            o_grant,
   input  logic                                 i_en,
   output logic                                 o_valid,
   output logic [DATA_WIDTH-1:0]                o_data_bus,
   input  logic                                 i_ready
`ifdef O_BUS_PICK_ID_EN
   ,
   output logic [$clog2(NUM_INPUT_DATA)-1:0]    o_id
`endif
);

   localparam int IW = $clog2(NUM_INPUT_DATA);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0]         rr_ptr;
   logic [IW-1:0]         grant_idx;
   logic                  grant_any;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic                  pop;
   logic                  push;
   logic                  can_push;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   assign pop      = (count != '0) && i_ready;
   // A full FIFO still accepts when its head leaves in the same cycle.
   assign can_push = (count != CW'(FIFO_DEPTH)) || pop;

   always_comb begin
      int j;
      j         = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_INPUT_DATA; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_INPUT_DATA) j = j - NUM_INPUT_DATA;
         if (!grant_any && i_valid[j]) begin
            grant_any = 1'b1;
            grant_idx = IW'(j);
         end
      end
      if (!(rst_n && i_en && can_push)) grant_any = 1'b0;
   end

   assign push = grant_any;

   always_comb begin
      o_grant = '0;
      if (grant_any) o_grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         rr_ptr <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= (grant_idx == IW'(NUM_INPUT_DATA - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is not reset; the empty-gated outputs hide stale entries.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= i_data_bus[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   assign o_valid    = (count != '0);
   assign o_data_bus = o_valid ? mem[rd_ptr] : '0;

`ifdef O_BUS_PICK_ID_EN
   logic [IW-1:0] id_mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr] <= grant_idx;
   end

   assign o_id = o_valid ? id_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_o_bus_rr_pick_fifo.sv
// Self-checking bench for o_bus_rr_pick_fifo (4 channels x 16 bits, depth 4):
// directed scenarios followed by randomized traffic against a queue-based model.
module tb_o_bus_rr_pick_fifo;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int D  = 4;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    i_valid;
   logic [N*DW-1:0] i_data_bus;
   logic [N-1:0]    o_grant;
   logic            i_en;
   logic            o_valid;
   logic [DW-1:0]   o_data_bus;
   logic            i_ready;
`ifdef O_BUS_PICK_ID_EN
   logic [1:0]      o_id;
   logic [1:0]      last_id;
`endif

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] q[$];
   int            qid[$];
   int            rr;

   logic [N-1:0]  last_grant;
   logic          last_valid;
   logic [DW-1:0] last_data;

   o_bus_rr_pick_fifo #(
      .NUM_INPUT_DATA(N),
      .DATA_WIDTH    (DW),
      .FIFO_DEPTH    (D)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_data_bus(i_data_bus),
      .o_grant   (o_grant),
      .i_en      (i_en),
      .o_valid   (o_valid),
      .o_data_bus(o_data_bus),
      .i_ready   (i_ready)
`ifdef O_BUS_PICK_ID_EN
      ,
      .o_id      (o_id)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
      i_data_bus = {d3, d2, d1, d0};
   endtask

   // One clock: apply inputs, check outputs at the falling edge, advance the model at the rising edge.
   task automatic step(input logic [N-1:0] v, input logic en, input logic rdy, input logic rstn);
      int            k;
      logic [N-1:0]  eg;
      logic [DW-1:0] ed;
      int            eid;
      i_valid = v;
      i_en    = en;
      i_ready = rdy;
      rst_n   = rstn;
      k = -1;
      if (rstn && en && (q.size() < D || (q.size() != 0 && rdy))) begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (rr + i) % N;
            if (k < 0 && v[j]) k = j;
         end
      end
      eg  = (k < 0) ? '0 : N'(1 << k);
      ed  = '0;
      eid = 0;
      if (q.size() != 0) begin
         ed  = q[0];
         eid = qid[0];
      end
      @(negedge clk);
      last_grant = o_grant;
      last_valid = o_valid;
      last_data  = o_data_bus;
      chk("grant", 32'(o_grant), 32'(eg));
      chk("valid", 32'(o_valid), 32'(q.size() != 0));
      chk("data", 32'(o_data_bus), 32'(ed));
`ifdef O_BUS_PICK_ID_EN
      last_id = o_id;
      chk("id", 32'(o_id), 32'(eid));
`endif
      @(posedge clk);
      if (!rstn) begin
         q.delete();
         qid.delete();
         rr = 0;
      end else begin
         if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
            void'(qid.pop_front());
         end
         if (k >= 0) begin
            q.push_back(i_data_bus[k*DW +: DW]);
            qid.push_back(k);
            rr = (k + 1) % N;
         end
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] fair_seq [5];
      fair_seq[0] = 4'b0001;
      fair_seq[1] = 4'b0010;
      fair_seq[2] = 4'b0100;
      fair_seq[3] = 4'b1000;
      fair_seq[4] = 4'b0001;

      rr = 0;
      rst_n = 1'b0;
      i_valid = '0;
      i_en = 1'b0;
      i_ready = 1'b0;
      i_data_bus = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      step(4'b1111, 1'b1, 1'b1, 1'b0);
      chk("reset_grant", 32'(last_grant), 32'h0);
      step(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("reset_valid", 32'(last_valid), 32'h0);
      chk("reset_data", 32'(last_data), 32'h0);

      // Single request on channel 2
      set_data(16'h0, 16'h0, 16'h1234, 16'h0);
      step(4'b0100, 1'b1, 1'b1, 1'b1);
      chk("single_grant", 32'(last_grant), 32'h4);
      step(4'b0000, 1'b1, 1'b1, 1'b1);
      chk("single_valid", 32'(last_valid), 32'h1);
      chk("single_data", 32'(last_data), 32'h1234);
      step(4'b1111, 1'b1, 1'b1, 1'b1);
      chk("single_rr_next", 32'(last_grant), 32'h8);

      // Fairness with all channels requesting
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      set_data(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3);
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1, 1'b1, 1'b1);
         chk("fair_grant", 32'(last_grant), 32'(fair_seq[i]));
         if (i > 0) chk("fair_data", 32'(last_data), 32'(16'h00C0 + ((i - 1) % N)));
`ifdef O_BUS_PICK_ID_EN
         if (i > 0) chk("fair_id", 32'(last_id), 32'((i - 1) % N));
`endif
      end
      step(4'b0000, 1'b1, 1'b1, 1'b1);
      chk("fair_data_last", 32'(last_data), 32'h00C0);

      // Backpressure: fill, stall, then drain in order
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      set_data(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, 1'b1, 1'b0, 1'b1);
         chk("bp_grant", 32'(last_grant), 32'(1 << i));
      end
      step(4'b1111, 1'b1, 1'b0, 1'b1);
      chk("bp_full_grant", 32'(last_grant), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(4'b0000, 1'b1, 1'b1, 1'b1);
         chk("bp_drain", 32'(last_data), 32'(16'h00A0 + i));
      end
      step(4'b0000, 1'b1, 1'b1, 1'b1);
      chk("bp_empty", 32'(last_valid), 32'h0);

      // Full FIFO with simultaneous push and pop
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0, 1'b1);
      set_data(16'hBEEF, 16'h00A1, 16'h00A2, 16'h00A3);
      step(4'b0001, 1'b1, 1'b1, 1'b1);
      chk("full_pp_grant", 32'(last_grant), 32'h1);
      chk("full_pp_head", 32'(last_data), 32'h00A0);
      step(4'b0001, 1'b1, 1'b0, 1'b1);
      chk("full_pp_stall", 32'(last_grant), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b1, 1'b1, 1'b1);
         chk("full_pp_order", 32'(last_data), 32'(16'h00A1 + i));
      end
      step(4'b0000, 1'b1, 1'b1, 1'b1);
      chk("full_pp_tail", 32'(last_data), 32'hBEEF);

      // Reset mid-operation
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      set_data(16'h0011, 16'h0022, 16'h0033, 16'h0044);
      for (int i = 0; i < 3; i++) step(4'b0111, 1'b1, 1'b0, 1'b1);
      step(4'b1000, 1'b1, 1'b0, 1'b0);
      chk("midrst_grant", 32'(last_grant), 32'h0);
      step(4'b1001, 1'b1, 1'b1, 1'b1);
      chk("midrst_valid", 32'(last_valid), 32'h0);
      chk("midrst_data", 32'(last_data), 32'h0);
      chk("midrst_first_grant", 32'(last_grant), 32'h1);

      // Output keeps draining while picking is disabled
      step(4'b1111, 1'b0, 1'b1, 1'b1);
      chk("en_off_grant", 32'(last_grant), 32'h0);
      chk("en_off_drain", 32'(last_data), 32'h0011);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         i_data_bus = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
         step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
